// File: rtl/barrel_pkg.sv
// -----------------------------------------------------------------------------
// barrel_pkg
//   Shared definitions for the pipelined barrel shifter: operation encodings
//   and a constant-function log2 for tools that lack $clog2.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package barrel_pkg;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
   localparam logic [1:0] MODE_ROL = 2'b11;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >>> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter_if
//   Operand/result bus of the pipelined barrel shifter with valid/ready
//   handshakes on both sides.
//   Signals:
//     in_valid, in_ready  input handshake
//     x                   operand
//     shift_n             shift amount, MSB flags amounts >= WIDTH
//     mode                00 SLL, 01 SRL, 10 SRA, 11 ROL
//     out_valid, out_ready output handshake
//     y, zero             result and (y == 0) flag
//   Modports: master drives operations and consumes results; slave is the
//   shifter.
// -----------------------------------------------------------------------------
interface pipelined_barrel_shifter_if #(
   parameter int WIDTH = 8
);
   localparam int SHIFT_W = barrel_pkg::clog2(WIDTH);
   localparam int AMT_W   = SHIFT_W + 1;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [AMT_W-1:0] shift_n;
   logic [1:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             zero;

   modport master (
      output in_valid, x, shift_n, mode, out_ready,
      input  in_ready, out_valid, y, zero
   );

   modport slave (
      input  in_valid, x, shift_n, mode, out_ready,
      output in_ready, out_valid, y, zero
   );

endinterface

// File: rtl/barrel_stage.sv
// -----------------------------------------------------------------------------
// barrel_stage
//   One registered log2 stage of the barrel shifter. Shifts or rotates the
//   incoming data by DIST when its amount bit is set, otherwise passes it
//   through, and forwards mode/amount/valid to the next stage.
//   Ports:
//     clk, rst_n           clock, synchronous active-low reset
//     en                   pipeline advance
//     vld_in/vld_out       stage valid
//     data_in/data_out     data word
//     mode_in/mode_out     operation
//     amt_in/amt_out       remaining shift amount
//     zero_out             registered (data_out == 0), final stage only
// -----------------------------------------------------------------------------
module barrel_stage
   import barrel_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIST  = 1,
   parameter bit LAST  = 1'b0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             en,
   input  logic                             vld_in,
   input  logic [WIDTH-1:0]                 data_in,
   input  logic [1:0]                       mode_in,
   input  logic [barrel_pkg::clog2(WIDTH)-1:0] amt_in,
   output logic                             vld_out,
   output logic [WIDTH-1:0]                 data_out,
   output logic [1:0]                       mode_out,
   output logic [barrel_pkg::clog2(WIDTH)-1:0] amt_out,
   output logic                             zero_out
);

   localparam int SHIFT_W = clog2(WIDTH);
   localparam int BIT     = clog2(DIST);

   function automatic logic [WIDTH-1:0] shift_dist(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       m);
      logic signed [WIDTH-1:0] sd;
      logic        [WIDTH-1:0] r;
      sd = d;
      case (m)
         MODE_SLL: r = d << DIST;
         MODE_SRL: r = d >> DIST;
         MODE_SRA: r = $unsigned(sd >>> DIST);
         default:  r = (d << DIST) | (d >> (WIDTH - DIST));
      endcase
      return r;
   endfunction

   logic [WIDTH-1:0]   shifted;
   logic               vld_q;
   logic [WIDTH-1:0]   data_q;
   logic [1:0]         mode_q;
   logic [SHIFT_W-1:0] amt_q;

   assign shifted = amt_in[BIT] ? shift_dist(data_in, mode_in) : data_in;

   // ---- stage register ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
      end else if (en) begin
         vld_q <= vld_in;
      end
   end

   always_ff @(posedge clk) begin
      if (LAST && !rst_n) begin
         data_q <= '0;
      end else if (en) begin
         data_q <= shifted;
         mode_q <= mode_in;
         amt_q  <= amt_in;
      end
   end

   if (LAST) begin : g_zero
      logic zero_q;
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            zero_q <= 1'b0;
         end else if (en) begin
            zero_q <= (shifted == '0);
         end
      end
      assign zero_out = zero_q;
   end else begin : g_no_zero
      assign zero_out = 1'b0;
   end

   assign vld_out  = vld_q;
   assign data_out = data_q;
   assign mode_out = mode_q;
   assign amt_out  = amt_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
//   Pipelined SLL/SRL/SRA/ROL barrel shifter with valid/ready flow control.
//   A capture stage resolves out-of-range amounts, then one barrel_stage per
//   shift-amount bit applies a power-of-two shift. All stages advance
//   together; a stalled output freezes the whole pipe. Latency SHIFT_W+1.
//   Ports:
//     clk    clock, all logic on posedge
//     rst_n  synchronous active-low reset (drops in-flight operations)
//     bus    pipelined_barrel_shifter_if.slave: operand in, result out
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter
   import barrel_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic                        clk,
   input logic                        rst_n,
   pipelined_barrel_shifter_if.slave  bus
);

   localparam int SHIFT_W = clog2(WIDTH);

   logic               adv;
   logic               ovf;
   logic [SHIFT_W-1:0] cap_amt;
   logic [WIDTH-1:0]   cap_data;

   logic               vld_p0;
   logic [WIDTH-1:0]   data_p0;
   logic [1:0]         mode_p0;
   logic [SHIFT_W-1:0] amt_p0;

   logic               st_vld  [1:SHIFT_W];
   logic [WIDTH-1:0]   st_data [1:SHIFT_W];
   logic [1:0]         st_mode [1:SHIFT_W];
   logic [SHIFT_W-1:0] st_amt  [1:SHIFT_W];
   logic               st_zero [1:SHIFT_W];

   // Only a held (valid, not accepted) result stops the pipe, so bubbles
   // are never squeezed out and the input side sees the same condition.
   assign adv          = !(bus.out_valid && !bus.out_ready);
   assign bus.in_ready = adv;

   // Out-of-range amounts are resolved here so later stages only see
   // amounts below WIDTH; rotate just wraps.
   always_comb begin
      ovf      = bus.shift_n[SHIFT_W];
      cap_data = bus.x;
      cap_amt  = bus.shift_n[SHIFT_W-1:0];
      if (ovf && (bus.mode != MODE_ROL)) begin
         cap_amt  = '0;
         cap_data = (bus.mode == MODE_SRA) ? {WIDTH{bus.x[WIDTH-1]}} : '0;
      end
   end

   // ---- stage 0: capture ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
      end else if (adv) begin
         vld_p0 <= bus.in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         data_p0 <= cap_data;
         mode_p0 <= bus.mode;
         amt_p0  <= cap_amt;
      end
   end

   // ---- stages 1..SHIFT_W: shift by 2^(k-1) ----
   for (genvar k = 1; k <= SHIFT_W; k++) begin : g_stage
      logic               v_in;
      logic [WIDTH-1:0]   d_in;
      logic [1:0]         m_in;
      logic [SHIFT_W-1:0] a_in;

      if (k == 1) begin : g_first
         assign v_in = vld_p0;
         assign d_in = data_p0;
         assign m_in = mode_p0;
         assign a_in = amt_p0;
      end else begin : g_next
         assign v_in = st_vld[k-1];
         assign d_in = st_data[k-1];
         assign m_in = st_mode[k-1];
         assign a_in = st_amt[k-1];
      end

      barrel_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << (k - 1)),
         .LAST  (k == SHIFT_W)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (adv),
         .vld_in   (v_in),
         .data_in  (d_in),
         .mode_in  (m_in),
         .amt_in   (a_in),
         .vld_out  (st_vld[k]),
         .data_out (st_data[k]),
         .mode_out (st_mode[k]),
         .amt_out  (st_amt[k]),
         .zero_out (st_zero[k])
      );
   end

   assign bus.out_valid = st_vld[SHIFT_W];
   assign bus.y         = st_data[SHIFT_W];
   assign bus.zero      = st_zero[SHIFT_W];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// tb_pipelined_barrel_shifter
//   Directed bench for pipelined_barrel_shifter at WIDTH=8: reset, single
//   operations per mode incl. out-of-range amounts, streaming, backpressure
//   and reset with operations in flight.
// -----------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;
   import barrel_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   pipelined_barrel_shifter_if #(.WIDTH(8)) bus ();

   pipelined_barrel_shifter #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Streaming table, expected values worked out by hand.
   logic [7:0] tx [8];
   logic [3:0] tn [8];
   logic [1:0] tm [8];
   logic [7:0] ty [8];
   logic       tz [8];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation into an empty pipe and check latency and result.
   task automatic run_one(input string tag, input logic [7:0] xv, input logic [3:0] nv,
                          input logic [1:0] mv, input logic [7:0] ey, input logic ez);
      int lat;
      bus.x         = xv;
      bus.shift_n   = nv;
      bus.mode      = mv;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      step();
      // Disturb inputs after acceptance; in-flight data must not change.
      bus.in_valid = 1'b0;
      bus.x        = ~xv;
      bus.shift_n  = 4'd0;
      bus.mode     = mv ^ 2'b01;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         step();
         lat++;
      end
      chk({tag, "_lat"}, lat, 4);
      chk({tag, "_y"}, bus.y, ey);
      chk({tag, "_zero"}, bus.zero, ez);
      step();
   endtask

   // Push the 8-entry table; out_ready drops for sl cycles starting at cycle st.
   task automatic stream(input string tag, input int st, input int sl);
      int         sent;
      int         rcv;
      int         cyc;
      int         idx;
      logic       holding;
      logic [7:0] held;
      sent    = 0;
      rcv     = 0;
      cyc     = 0;
      holding = 1'b0;
      held    = '0;
      while (rcv < 8 && cyc < 60) begin
         idx           = (sent < 8) ? sent : 0;
         bus.in_valid  = (sent < 8);
         bus.x         = tx[idx];
         bus.shift_n   = tn[idx];
         bus.mode      = tm[idx];
         bus.out_ready = !(cyc >= st && cyc < st + sl);
         #1;
         if (bus.out_valid && !bus.out_ready) begin
            chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
            if (holding) chk({tag, "_hold_y"}, bus.y, held);
            held    = bus.y;
            holding = 1'b1;
         end else begin
            holding = 1'b0;
         end
         if (bus.out_valid && bus.out_ready) begin
            chk({tag, "_y"}, bus.y, ty[rcv]);
            chk({tag, "_zero"}, bus.zero, tz[rcv]);
            if (sl == 0) chk({tag, "_cycle"}, cyc, 4 + rcv);
            rcv++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
         step();
         cyc++;
      end
      chk({tag, "_count"}, rcv, 8);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      chk({tag, "_no_dup"}, bus.out_valid, 1'b0);
   endtask

   initial begin
      int seen;
      checks   = 0;
      failures = 0;

      tx = '{8'h1A, 8'h1A, 8'h1A, 8'h1A, 8'h9A, 8'h9A, 8'h9A, 8'h81};
      tn = '{4'd3,  4'd0,  4'd5,  4'd9,  4'd2,  4'd12, 4'd9,  4'd8};
      tm = '{MODE_SLL, MODE_SRL, MODE_ROL, MODE_ROL, MODE_SRA, MODE_SRA, MODE_SRL, MODE_ROL};
      ty = '{8'hD0, 8'h1A, 8'h43, 8'h34, 8'hE6, 8'hFF, 8'h00, 8'h81};
      tz = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};

      // Reset with a valid operation presented.
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.x         = 8'h1A;
      bus.shift_n   = 4'd3;
      bus.mode      = MODE_SLL;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_out_valid", bus.out_valid, 1'b0);
         chk("rst_y", bus.y, 8'h00);
         chk("rst_zero", bus.zero, 1'b0);
      end
      rst_n = 1'b1;
      run_one("first_after_rst", 8'h1A, 4'd3, MODE_SLL, 8'hD0, 1'b0);

      // Directed single operations.
      run_one("srl0",   8'h1A, 4'd0,  MODE_SRL, 8'h1A, 1'b0);
      run_one("rol5",   8'h1A, 4'd5,  MODE_ROL, 8'h43, 1'b0);
      run_one("rol9",   8'h1A, 4'd9,  MODE_ROL, 8'h34, 1'b0);
      run_one("sra2",   8'h9A, 4'd2,  MODE_SRA, 8'hE6, 1'b0);
      run_one("sra12",  8'h9A, 4'd12, MODE_SRA, 8'hFF, 1'b0);
      run_one("srl9",   8'h9A, 4'd9,  MODE_SRL, 8'h00, 1'b1);
      run_one("srl7",   8'h9A, 4'd7,  MODE_SRL, 8'h01, 1'b0);
      run_one("sra15p", 8'h7A, 4'd15, MODE_SRA, 8'h00, 1'b1);
      run_one("sll8",   8'hFF, 4'd8,  MODE_SLL, 8'h00, 1'b1);
      run_one("sll0",   8'h9A, 4'd0,  MODE_SLL, 8'h9A, 1'b0);
      run_one("sra0",   8'h9A, 4'd0,  MODE_SRA, 8'h9A, 1'b0);

      // Back-to-back and with a 5-cycle output stall.
      stream("stream", 0, 0);
      stream("bp", 6, 5);

      // Reset with three operations in flight.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.x        = tx[i];
         bus.shift_n  = tn[i];
         bus.mode     = tm[i];
         step();
      end
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      step();
      chk("midrst_out_valid", bus.out_valid, 1'b0);
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.out_valid) seen++;
      end
      chk("midrst_flushed", seen, 0);
      run_one("after_midrst", 8'h9A, 4'd2, MODE_SRA, 8'hE6, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
